// File: rtl/ripple_add_sequencer_if.sv
// Start/done request bus between a requester and the ripple-add sequencer.
interface ripple_add_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/ripple_add_sequencer.sv
// Wide adder that pushes one nibble per cycle through a single 4-bit ripple slice,
// carrying between nibbles through a register.
//
// state | meaning
// IDLE  | waiting for start; sum/cout hold the last result
// RUN   | one nibble per cycle, LSB nibble first
// DONE  | one-cycle done pulse, sum/cout valid
module ripple_add_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    ripple_add_sequencer_if.slave      bus
);
    localparam int N  = WIDTH / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;

    logic [3:0]       nib_a, nib_b;
    logic [4:0]       slice;
    logic [WIDTH-1:0] nib_ext;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;

        // 4-bit slice: the only combinational carry path in the block
        nib_a   = 4'(a_q >> {cnt_q, 2'b00});
        nib_b   = 4'(b_q >> {cnt_q, 2'b00});
        slice   = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry_q};
        nib_ext = '0;
        nib_ext[3:0] = slice[3:0];
        nib_ext = nib_ext << {cnt_q, 2'b00};

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d   = sum_q | nib_ext;
                carry_d = slice[4];
                if (cnt_q == LAST) begin
                    cout_d  = slice[4];
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_ripple_add_sequencer.sv
// Directed bench for ripple_add_sequencer (WIDTH=16).
module tb_ripple_add_sequencer;
    localparam int WIDTH = 16;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    int   done_cnt = 0;

    ripple_add_sequencer_if #(.WIDTH(WIDTH)) bus ();

    ripple_add_sequencer #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a request at a negedge; return after the accepting posedge, at the next negedge.
    task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic cv);
        @(negedge clk);
        bus.a = av; bus.b = bv; bus.cin = cv; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Wait (bounded) for done, sampling at negedges; cycles = posedges since the accept edge.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (bus.done !== 1'b1 && cycles < 20) begin
            @(posedge clk);
            @(negedge clk);
            cycles++;
        end
    endtask

    initial begin
        int cyc;
        int d0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;

        // 1: reset with random inputs
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.start = 1'($urandom); bus.a = 16'($urandom); bus.b = 16'($urandom); bus.cin = 1'($urandom);
        end
        #1;
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_sum",  32'(bus.sum), 0);
        check("rst_cout", 32'(bus.cout), 0);
        @(negedge clk);
        bus.start = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", 32'(bus.busy), 0);
        check("idle_sum",  32'(bus.sum), 0);
        check("idle_done_cnt", 32'(done_cnt), 0);

        // 2: basic add and latency
        issue(16'h1234, 16'h4321, 1'b0);
        bus.start = 1'b0;
        check("run_busy", 32'(bus.busy), 1);
        wait_done(cyc);
        check("lat_basic", 32'(cyc), 4);
        check("sum_basic", 32'(bus.sum), 32'h5555);
        check("cout_basic", 32'(bus.cout), 0);
        check("done_busy", 32'(bus.busy), 1);
        @(negedge clk);
        check("done_pulse", 32'(bus.done), 0);
        check("post_busy", 32'(bus.busy), 0);
        check("sum_held", 32'(bus.sum), 32'h5555);

        // 3: carry ripples through all nibbles
        issue(16'hFFFF, 16'h0000, 1'b1);
        bus.start = 1'b0;
        wait_done(cyc);
        check("lat_ripple", 32'(cyc), 4);
        check("sum_ripple", 32'(bus.sum), 32'h0000);
        check("cout_ripple", 32'(bus.cout), 1);

        // 4: overflow cases
        @(negedge clk);
        issue(16'hFFFF, 16'hFFFF, 1'b1);
        bus.start = 1'b0;
        wait_done(cyc);
        check("sum_ovf1", 32'(bus.sum), 32'hFFFF);
        check("cout_ovf1", 32'(bus.cout), 1);
        @(negedge clk);
        issue(16'h8000, 16'h8000, 1'b0);
        bus.start = 1'b0;
        check("sum_clr_on_start", 32'(bus.sum), 0);
        wait_done(cyc);
        check("sum_ovf2", 32'(bus.sum), 32'h0000);
        check("cout_ovf2", 32'(bus.cout), 1);

        // 5: start held and operands changed during RUN, then held through done
        @(negedge clk);
        d0 = done_cnt;
        issue(16'h1111, 16'h2222, 1'b0);
        bus.a = 16'hAAAA; bus.b = 16'h5555;
        wait_done(cyc);
        check("lat_proto", 32'(cyc), 4);
        check("sum_proto1", 32'(bus.sum), 32'h3333);
        check("cout_proto1", 32'(bus.cout), 0);
        @(negedge clk);
        check("proto_idle", 32'(bus.busy), 0);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check("proto_reaccept", 32'(bus.busy), 1);
        wait_done(cyc);
        check("sum_proto2", 32'(bus.sum), 32'hFFFF);
        check("cout_proto2", 32'(bus.cout), 0);
        repeat (6) @(negedge clk);
        check("proto_done_count", 32'(done_cnt - d0), 2);

        // 6: async reset in RUN cycle 2
        d0 = done_cnt;
        issue(16'h1234, 16'h4321, 1'b0);
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check("partial_sum", 32'(bus.sum), 32'h0055);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_sum",  32'(bus.sum), 0);
        check("abort_cout", 32'(bus.cout), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - d0), 0);
        issue(16'h0001, 16'h0001, 1'b0);
        bus.start = 1'b0;
        wait_done(cyc);
        check("lat_after_rst", 32'(cyc), 4);
        check("sum_after_rst", 32'(bus.sum), 32'h0002);
        check("cout_after_rst", 32'(bus.cout), 0);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
